ws2812_strip_driver: RTL and testbench

WS2812_STRIP_DRIVER -- requirements
Module: ws2812_strip_driver

---
 rtl/ws2812_pkg.sv | 16 +
 rtl/ws2812_bit_timer.sv | 47 ++++
 rtl/ws2812_strip_driver.sv | 134 +++++++++++++
 tb/tb_ws2812_strip_driver.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared state encoding and time-to-cycle conversion for the WS2812 strip driver.
package ws2812_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, HIGH, LOW, LATCH} state_t;

  localparam longint NS_DIV = 64'd1_000_000_000;
  localparam longint US_DIV = 64'd1_000_000;

  // Truncating conversion; never returns less than one cycle.
  function automatic int to_cycles(input longint t, input longint f_clk, input longint div);
    longint c;
    c = t * f_clk / div;
    return (c < 64'sd1) ? 1 : int'(c);
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Generates one WS2812 bit: high then low phase, lengths picked by the live bit value.
module ws2812_bit_timer #(
  parameter int T0H = 4,
  parameter int T0L = 9,
  parameter int T1H = 8,
  parameter int T1L = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_val,
  input  logic go,
  output logic line,
  output logic high_done,
  output logic bit_done
);

  logic        active, hi;
  logic [31:0] cnt, lim;
  logic        end_ph;

  // bit_val must stay stable for the whole bit; the parent holds it in its shift register
  assign lim = hi ? (bit_val ? 32'(T1H) : 32'(T0H))
                  : (bit_val ? 32'(T1L) : 32'(T0L));
  assign end_ph    = active && (cnt == lim - 32'd1);
  assign high_done = end_ph && hi;
  assign bit_done  = end_ph && !hi;
  assign line      = active && hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      hi     <= 1'b0;
      cnt    <= '0;
    end else if (go) begin
      active <= 1'b1;
      hi     <= 1'b1;
      cnt    <= '0;
    end else if (end_ph) begin
      active <= hi;
      hi     <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ws2812_strip_driver.sv
// WS2812 frame sequencer: pixel fetch, one-entry holding register, latch timing.
// Optional WS2812_UNDERRUN_EN adds a sticky Underrun output.
module ws2812_strip_driver
  import ws2812_pkg::*;
#(
  parameter int F_CLK     = 12_000_000,
  parameter int BITWIDTH  = 24,
  parameter int NUM_LEDS  = 8,
  parameter int T0H_NS    = 350,
  parameter int T0L_NS    = 800,
  parameter int T1H_NS    = 700,
  parameter int T1L_NS    = 600,
  parameter int TRESET_US = 60
) (
  input  logic                Clk,
  input  logic                Reset_N,
  input  logic                Start,
  input  logic [BITWIDTH-1:0] Pixel_Data,
  input  logic                Pixel_Valid,
  output logic                Pixel_Ready,
  output logic                Busy,
  output logic                Frame_Done,
  output logic                WS2812OUT
`ifdef WS2812_UNDERRUN_EN
  , output logic              Underrun
`endif
);

  localparam int T0H = to_cycles(longint'(T0H_NS), longint'(F_CLK), NS_DIV);
  localparam int T0L = to_cycles(longint'(T0L_NS), longint'(F_CLK), NS_DIV);
  localparam int T1H = to_cycles(longint'(T1H_NS), longint'(F_CLK), NS_DIV);
  localparam int T1L = to_cycles(longint'(T1L_NS), longint'(F_CLK), NS_DIV);
  localparam int TRS = to_cycles(longint'(TRESET_US), longint'(F_CLK), US_DIV);
  localparam int PW  = $clog2(NUM_LEDS + 1);
  localparam int BIW = $clog2(BITWIDTH);

  state_t              state, nxt;
  logic [BITWIDTH-1:0] sh, hold, src;
  logic                hold_v;
  logic [PW-1:0]       pix_cnt;
  logic [BIW-1:0]      bit_idx;
  logic [31:0]         lat_cnt;
  logic                line, high_done, bit_done, go;
  logic                xfer, last_bit, last_pix, load_first, load_next, lat_end;

  assign xfer       = Pixel_Valid && Pixel_Ready;
  assign last_bit   = bit_done && (bit_idx == BIW'(BITWIDTH - 1));
  assign last_pix   = (pix_cnt == PW'(NUM_LEDS));
  assign lat_end    = (state == LATCH) && (lat_cnt == 32'(TRS - 1));
  assign load_first = (state == FETCH) && xfer;
  assign load_next  = last_bit && !last_pix;
  assign go         = load_first || load_next || (bit_done && !last_bit);
  // Same-cycle transfer bypasses the empty holding register; otherwise a zero pixel fills the slot
  assign src        = hold_v ? hold : (xfer ? Pixel_Data : '0);

  ws2812_bit_timer #(.T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L)) u_bit (
    .clk       (Clk),
    .rst_n     (Reset_N),
    .bit_val   (sh[BITWIDTH-1]),
    .go        (go),
    .line      (line),
    .high_done (high_done),
    .bit_done  (bit_done)
  );

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (Start)     nxt = FETCH;
      FETCH:   if (xfer)      nxt = HIGH;
      HIGH:    if (high_done) nxt = LOW;
      LOW:     if (bit_done)  nxt = (last_bit && last_pix) ? LATCH : HIGH;
      LATCH:   if (lat_end)   nxt = IDLE;
      default:                nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy        = (state != IDLE);
    Pixel_Ready = Busy && !hold_v && (pix_cnt < PW'(NUM_LEDS));
    Frame_Done  = lat_end;
    WS2812OUT   = line && (state == HIGH);
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      sh      <= '0;
      hold    <= '0;
      hold_v  <= 1'b0;
      pix_cnt <= '0;
      bit_idx <= '0;
      lat_cnt <= '0;
    end else begin
      lat_cnt <= (state == LATCH) ? lat_cnt + 32'd1 : 32'd0;
      if (state == IDLE) begin
        pix_cnt <= '0;
        hold_v  <= 1'b0;
      end
      if (load_first) begin
        sh      <= Pixel_Data;
        pix_cnt <= PW'(1);
        bit_idx <= '0;
      end else if (load_next) begin
        sh      <= src;
        pix_cnt <= pix_cnt + PW'(1);
        bit_idx <= '0;
        hold_v  <= 1'b0;
      end else begin
        if (bit_done) begin
          sh      <= {sh[BITWIDTH-2:0], 1'b0};
          bit_idx <= bit_idx + BIW'(1);
        end
        if (xfer) begin
          hold   <= Pixel_Data;
          hold_v <= 1'b1;
        end
      end
    end
  end

`ifdef WS2812_UNDERRUN_EN
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N)                     Underrun <= 1'b0;
    else if (state == IDLE && Start)  Underrun <= 1'b0;
    else if (load_next && !hold_v && !xfer) Underrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Directed bench: four driver configurations, pulse-width monitor, hand-computed expectations.
module tb_ws2812_strip_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_n, start, valid, ready, busy, done, out, ur;
  logic [31:0] pd [4];
  int tests = 0, fails = 0;
  int dc;

  int nb[4], hc[4], lc[4], dn[4], dl[4], xc[4];
  int hl[4][128], ll[4][128];
  logic prev[4];

  ws2812_strip_driver #(.NUM_LEDS(1)) u0 (
    .Clk(clk), .Reset_N(rst_n[0]), .Start(start[0]), .Pixel_Data(pd[0][23:0]),
    .Pixel_Valid(valid[0]), .Pixel_Ready(ready[0]), .Busy(busy[0]),
    .Frame_Done(done[0]), .WS2812OUT(out[0])
`ifdef WS2812_UNDERRUN_EN
    , .Underrun(ur[0])
`endif
  );
  ws2812_strip_driver #(.NUM_LEDS(3)) u1 (
    .Clk(clk), .Reset_N(rst_n[1]), .Start(start[1]), .Pixel_Data(pd[1][23:0]),
    .Pixel_Valid(valid[1]), .Pixel_Ready(ready[1]), .Busy(busy[1]),
    .Frame_Done(done[1]), .WS2812OUT(out[1])
`ifdef WS2812_UNDERRUN_EN
    , .Underrun(ur[1])
`endif
  );
  ws2812_strip_driver #(.NUM_LEDS(2)) u2 (
    .Clk(clk), .Reset_N(rst_n[2]), .Start(start[2]), .Pixel_Data(pd[2][23:0]),
    .Pixel_Valid(valid[2]), .Pixel_Ready(ready[2]), .Busy(busy[2]),
    .Frame_Done(done[2]), .WS2812OUT(out[2])
`ifdef WS2812_UNDERRUN_EN
    , .Underrun(ur[2])
`endif
  );
  ws2812_strip_driver #(.NUM_LEDS(1), .BITWIDTH(32)) u3 (
    .Clk(clk), .Reset_N(rst_n[3]), .Start(start[3]), .Pixel_Data(pd[3]),
    .Pixel_Valid(valid[3]), .Pixel_Ready(ready[3]), .Busy(busy[3]),
    .Frame_Done(done[3]), .WS2812OUT(out[3])
`ifdef WS2812_UNDERRUN_EN
    , .Underrun(ur[3])
`endif
  );

`ifndef WS2812_UNDERRUN_EN
  assign ur = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-instance run lengths: hl/ll hold high/low cycles of each bit, dl the low run at Frame_Done
  initial begin
    for (int k = 0; k < 4; k++) prev[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (out[k]) begin
          if (!prev[k]) begin
            if (nb[k] > 0 && nb[k] <= 128) ll[k][nb[k]-1] = lc[k];
            hc[k] = 1;
            nb[k]++;
          end else hc[k]++;
        end else begin
          if (prev[k]) begin
            if (nb[k] > 0 && nb[k] <= 128) hl[k][nb[k]-1] = hc[k];
            lc[k] = 1;
          end else lc[k]++;
        end
        if (done[k]) begin dn[k]++; dl[k] = lc[k]; end
        if (valid[k] && ready[k]) xc[k]++;
        prev[k] = out[k];
      end
    end
  end

  task automatic clr(input int k);
    #1;
    nb[k] = 0; hc[k] = 0; lc[k] = 0; dn[k] = 0; dl[k] = 0; xc[k] = 0;
  endtask

  task automatic frame(input int k, input int poke, output int dcyc);
    int c;
    @(negedge clk) start[k] = 1'b1;
    @(negedge clk) start[k] = 1'b0;
    c = 1;
    chk($sformatf("u%0d_busy_rise", k), busy[k], 1);
    chk($sformatf("u%0d_fetch_out", k), out[k], 0);
    while (!done[k] && c < 3000) begin
      @(negedge clk);
      c++;
      start[k] = (c == poke);
    end
    start[k] = 1'b0;
    dcyc = c;
    chk($sformatf("u%0d_done_seen", k), done[k], 1);
    chk($sformatf("u%0d_busy_at_done", k), busy[k], 1);
    @(negedge clk);
    chk($sformatf("u%0d_busy_fall", k), busy[k], 0);
    chk($sformatf("u%0d_done_pulse", k), done[k], 0);
  endtask

  task automatic feed(input int k, input int n, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic keep);
    int i, c;
    logic [31:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    i = 0; c = 0;
    pd[k] = w[0];
    valid[k] = 1'b1;
    while (i < n && c < 3000) begin
      @(negedge clk);
      c++;
      if (ready[k]) begin
        @(posedge clk); #1;
        i++;
        if (i < n) pd[k] = w[i];
      end
    end
    chk($sformatf("u%0d_feed", k), i, n);
    valid[k] = keep;
  endtask

  task automatic chk_bits(input int k, input int n, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input int bw);
    logic [31:0] w;
    logic b;
    for (int i = 0; i < n; i++) begin
      w = (i / bw == 0) ? w0 : (i / bw == 1) ? w1 : w2;
      b = w[bw - 1 - (i % bw)];
      chk($sformatf("u%0d_hi%0d", k, i), hl[k][i], b ? 8 : 4);
      if (i < n - 1) chk($sformatf("u%0d_lo%0d", k, i), ll[k][i], b ? 7 : 9);
    end
  endtask

  initial begin
    int c;
    rst_n = '0; start = '0; valid = '0;
    for (int k = 0; k < 4; k++) begin pd[k] = '0; clr(k); end
    repeat (3) @(negedge clk);
    chk("rst_busy", {28'd0, busy}, 0);
    chk("rst_out", {28'd0, out}, 0);
    chk("rst_ready", {28'd0, ready}, 0);
    chk("rst_done", {28'd0, done}, 0);
    chk("rst_underrun", {28'd0, ur}, 0);
    rst_n = '1;
    @(negedge clk);
    chk("idle_busy", {28'd0, busy}, 0);

    // single pixel, Start poked mid-latch must be ignored
    clr(0); pd[0] = 32'h0080_0000; valid[0] = 1'b1;
    frame(0, 600, dc);
    chk("u0_done_cyc", dc, 1035);
    chk("u0_bits", nb[0], 24);
    chk_bits(0, 24, 32'h0080_0000, 0, 0, 24);
    chk("u0_latch_lo", dl[0], 729);
    chk("u0_done_cnt", dn[0], 1);
    chk("u0_xfers", xc[0], 1);
    repeat (5) @(negedge clk);
    chk("u0_start_ignored", busy[0], 0);
    chk("u0_idle_out", out[0], 0);
    valid[0] = 1'b0;

    // three pixels, Valid held high, contiguous bits
    clr(1);
    fork
      feed(1, 3, 32'h00A5_0FC3, 32'h003C_F081, 32'h00FF_005A, 1'b1);
      frame(1, -1, dc);
    join
    chk("u1_bits", nb[1], 72);
    chk("u1_xfers", xc[1], 3);
    chk_bits(1, 72, 32'h00A5_0FC3, 32'h003C_F081, 32'h00FF_005A, 24);
    chk("u1_latch_lo", dl[1], 729);
    chk("u1_done_cnt", dn[1], 1);
    valid[1] = 1'b0;

    // second pixel withheld: zero pixel fills the slot
    clr(2);
    fork
      feed(2, 1, 32'h00C0_0001, 0, 0, 1'b0);
      frame(2, -1, dc);
    join
    chk("u2_bits", nb[2], 48);
    chk("u2_xfers", xc[2], 1);
    chk_bits(2, 48, 32'h00C0_0001, 0, 0, 24);
    chk("u2_latch_lo", dl[2], 729);
    chk("u2_done_cnt", dn[2], 1);
`ifdef WS2812_UNDERRUN_EN
    chk("u2_underrun", ur[2], 1);
`endif

    // reset at bit 10 of pixel 1, then a clean frame
    clr(1); pd[1] = 32'h00FF_FFFF; valid[1] = 1'b1;
    @(negedge clk) start[1] = 1'b1;
    @(negedge clk) start[1] = 1'b0;
    c = 0;
    while (nb[1] < 11 && c < 3000) begin @(negedge clk); #1; c++; end
    chk("u1_rst_point", nb[1], 11);
    chk("u1_pre_rst_out", out[1], 1);
    rst_n[1] = 1'b0;
    #1;
    chk("u1_rst_out", out[1], 0);
    chk("u1_rst_busy", busy[1], 0);
    chk("u1_rst_ready", ready[1], 0);
    chk("u1_rst_done", done[1], 0);
    repeat (5) @(negedge clk);
    chk("u1_rst_no_done", dn[1], 0);
    rst_n[1] = 1'b1;
    clr(1);
    frame(1, -1, dc);
    chk("u1b_bits", nb[1], 72);
    chk("u1b_xfers", xc[1], 3);
    chk_bits(1, 72, 32'h00FF_FFFF, 32'h00FF_FFFF, 32'h00FF_FFFF, 24);
    chk("u1b_latch_lo", dl[1], 727);
    chk("u1b_done_cnt", dn[1], 1);
    valid[1] = 1'b0;

    // 32-bit GRBW pixel, all ones
    clr(3); pd[3] = 32'hFFFF_FFFF; valid[3] = 1'b1;
    frame(3, -1, dc);
    chk("u3_done_cyc", dc, 1201);
    chk("u3_bits", nb[3], 32);
    chk_bits(3, 32, 32'hFFFF_FFFF, 0, 0, 32);
    chk("u3_latch_lo", dl[3], 727);
    chk("u3_done_cnt", dn[3], 1);
    valid[3] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
